fifo_pool_unpacker: RTL and testbench
=====================================

Name: fifo_pool_unpacker

Overview:
- Drains the 16-bit read side of the pool FIFO and re-pairs consecutive half-words into the original 32-bit words.
- The first half-word read becomes bits [15:0]; the second becomes bits [31:16]. This undoes the half-swap applied on the pool write side.
- Presents words on a valid/ready stream with a 2-entry output buffer and burst framing (out_last).
- Sits in the single pool read clock domain, between the pool FIFO and the downstream DMA/link packer.

Parameters:
- BURST_WORDS, 256: 32-bit words per burst; out_last asserted on the final word. Legal range 1..65535.
- CNT_W, 16: width of burst_cnt and total_cnt.

Ports:
- clk  in  1  pool read clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new FIFO reads. Deassertion stops issuing reads; in-flight data still completes.
- flush  in  1  synchronous discard of held half-word, output buffer and in-flight read data.
- fifo_rd_en  out  1  read strobe to the pool FIFO.
- fifo_rd_empty  in  1  pool FIFO empty.
- fifo_rd_data  in  16  pool FIFO data, valid exactly 1 cycle after fifo_rd_en (standard, non-FWFT FIFO).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  reassembled word.
- out_last  out  1  last word of a burst; qualified by out_valid.
- half_pending  out  1  a low half is held, waiting for its partner.
- total_cnt  out  CNT_W  32-bit words accepted downstream since reset/flush; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, async): fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, half_pending=0, total_cnt=0. Internal state also clears: rd_inflight=0, buffer occupancy occ=0, burst_cnt=0, phase=LOW.
- Read pipeline:
  - rd_inflight is a register: rd_inflight <= fifo_rd_en.
  - When rd_inflight=1, fifo_rd_data is captured.
  - With phase=LOW, the captured value goes to the low register, half_pending=1, phase becomes HIGH.
  - With phase=HIGH, the word {fifo_rd_data, low} is pushed into the output buffer, half_pending=0, phase becomes LOW.
- Read issue rule: fifo_rd_en = enable & ~fifo_rd_empty & ~flush & credit_ok.
  - credit_ok holds when occ_next_committed + ((half_pending + rd_inflight + 1) >> 1) <= 2.
  - Consequence: a completing high half always has a free buffer slot. The buffer never overflows and no word is ever dropped.
- Output buffer:
  - 2-entry FIFO; out_data/out_valid/out_last come from the head register.
  - A push and a pop in the same cycle are both honoured; occ is unchanged.
  - Push into an empty buffer: out_valid=1 on the next cycle.
- Latency and throughput:
  - Latency is 3 cycles from the read of the high half (fifo_rd_en=1) to out_valid=1: data at +1, buffer push at +2, visible at +3 (registered head).
  - Sustained throughput is 1 word per 2 cycles, limited by the FIFO width.
- Framing:
  - burst_cnt counts pops (out_valid & out_ready).
  - out_last = (words_ahead_of_head + burst_cnt == BURST_WORDS-1), computed when the word enters the buffer and stored per entry.
  - On popping a last word, burst_cnt returns to 0.
  - BURST_WORDS=1: every word has out_last=1.
- total_cnt increments on every pop and wraps to 0 after 2^CNT_W-1.
- AXI-style stability: once out_valid=1, out_data and out_last stay constant until accepted.
- Flush (flush=1 at a rising edge):
  - Next cycle: out_valid=0, occ=0, half_pending=0, phase=LOW, burst_cnt=0, total_cnt=0.
  - Read data returning in the cycle after flush (rd_inflight set before flush) is discarded.
  - fifo_rd_en=0 during the flush cycle.
- Boundary cases:
  - FIFO goes empty with a low half held: half_pending stays 1 indefinitely; no partial word is emitted.
  - enable=0 holds all state; buffered words still drain.
  - out_ready=0 with a full buffer: fifo_rd_en stays 0.
  - Async reset mid-burst: everything clears immediately; no output glitch other than deassertion.

Test Plan:
- FIFO preloaded with 0x1111,0x2222,0x3333,0x4444; enable=1, out_ready=1 -> out_data 0x22221111 then 0x44443333; first out_valid 3 cycles after the second fifo_rd_en; total_cnt=2.
- BURST_WORDS=4; 10 words streamed -> out_last high on words 4 and 8 only; burst_cnt=2 after the stream; total_cnt=10.
- out_ready held 0 for 50 cycles with a full FIFO -> fifo_rd_en stops after occ=2 plus one held half. Release -> no lost or duplicated words; the sequence matches the input pairing exactly.
- FIFO holds 3 half-words (0xA,0xB,0xC) -> one word 0x000B000A, then half_pending=1. Push 0xD -> 0x000D000C appears and half_pending=0.
- flush asserted while rd_inflight=1 with occ=1 -> next cycle out_valid=0, half_pending=0, total_cnt=0. The returning half-word is dropped; the following pair from the FIFO starts a fresh low half.
- rst_n pulsed low asynchronously mid-stream (not clock-aligned) -> all outputs 0 within the reset window; after release, normal pairing restarts from the next FIFO word.

Source files
------------

// File: rtl/fifo_pool_unpacker_if.sv
// Pool FIFO read port and reassembled-word stream, bundled for the unpacker.
// master: the unpacker side; slave: the FIFO/consumer side.
interface fifo_pool_unpacker_if;
    logic        fifo_rd_en;
    logic        fifo_rd_empty;
    logic [15:0] fifo_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_empty,
        input  fifo_rd_data,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_empty,
        output fifo_rd_data,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo_pool_unpacker.sv
// Re-pairs 16-bit pool FIFO half-words into 32-bit words (first half low) and
// streams them through a 2-entry buffer with burst framing.
module fifo_pool_unpacker #(
    parameter int unsigned BURST_WORDS = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 flush,
    fifo_pool_unpacker_if.master bus,
    output logic                 half_pending,
    output logic [CNT_W-1:0]     total_cnt
);

    typedef enum logic {PhLow, PhHigh} phase_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BURST_WORDS - 1);

    phase_e             phase_q, phase_d;
    logic               rd_inflight_q;
    logic               cap_valid_q, cap_valid_d;
    logic [15:0]        cap_data_q, cap_data_d;
    logic [15:0]        low_q, low_d;
    logic [1:0]         occ_q, occ_d;
    logic [31:0]        head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic               head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
    logic [CNT_W-1:0]   total_cnt_q, total_cnt_d;

    logic               rd_en;
    logic               pop, push, word_last, wr_tail, credit_ok;
    logic [31:0]        word;
    logic [2:0]         occ_nf, need;

    always_comb begin
        pop       = (occ_q != 2'd0) & bus.out_ready;
        push      = cap_valid_q & (phase_q == PhHigh);
        word      = {cap_data_q, low_q};
        word_last = (push_cnt_q == LastIdx);

        phase_d = phase_q;
        low_d   = low_q;
        if (cap_valid_q) begin
            unique case (phase_q)
                PhLow: begin
                    low_d   = cap_data_q;
                    phase_d = PhHigh;
                end
                PhHigh:  phase_d = PhLow;
                default: phase_d = PhLow;
            endcase
        end

        // Reserve a slot for every word the held/in-flight halves plus this read can complete.
        occ_nf    = {1'b0, occ_q} + {2'b0, push} - {2'b0, pop};
        need      = ({2'b0, phase_d == PhHigh} + {2'b0, rd_inflight_q} + 3'd1) >> 1;
        credit_ok = (occ_nf + need) <= 3'd2;
        rd_en     = rst_n & enable & ~bus.fifo_rd_empty & ~flush & credit_ok;

        cap_valid_d = rd_inflight_q & ~flush;
        cap_data_d  = rd_inflight_q ? bus.fifo_rd_data : cap_data_q;

        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        if (pop) begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
        end
        wr_tail = (occ_q == 2'd2) | ((occ_q == 2'd1) & ~pop);
        if (push) begin
            if (wr_tail) begin
                tail_data_d = word;
                tail_last_d = word_last;
            end else begin
                head_data_d = word;
                head_last_d = word_last;
            end
        end
        occ_d = occ_nf[1:0];

        burst_cnt_d = burst_cnt_q;
        if (pop) burst_cnt_d = head_last_q ? '0 : burst_cnt_q + 1'b1;
        push_cnt_d = push_cnt_q;
        if (push) push_cnt_d = word_last ? '0 : push_cnt_q + 1'b1;
        total_cnt_d = total_cnt_q + CNT_W'(pop);

        if (flush) begin
            phase_d     = PhLow;
            occ_d       = 2'd0;
            burst_cnt_d = '0;
            push_cnt_d  = '0;
            total_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PhLow;
            rd_inflight_q <= 1'b0;
            cap_valid_q   <= 1'b0;
            cap_data_q    <= '0;
            low_q         <= '0;
            occ_q         <= 2'd0;
            head_data_q   <= '0;
            head_last_q   <= 1'b0;
            tail_data_q   <= '0;
            tail_last_q   <= 1'b0;
            burst_cnt_q   <= '0;
            push_cnt_q    <= '0;
            total_cnt_q   <= '0;
        end else begin
            phase_q       <= phase_d;
            rd_inflight_q <= rd_en;
            cap_valid_q   <= cap_valid_d;
            cap_data_q    <= cap_data_d;
            low_q         <= low_d;
            occ_q         <= occ_d;
            head_data_q   <= head_data_d;
            head_last_q   <= head_last_d;
            tail_data_q   <= tail_data_d;
            tail_last_q   <= tail_last_d;
            burst_cnt_q   <= burst_cnt_d;
            push_cnt_q    <= push_cnt_d;
            total_cnt_q   <= total_cnt_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = (occ_q != 2'd0);
    assign bus.out_data   = head_data_q;
    assign bus.out_last   = head_last_q & (occ_q != 2'd0);
    assign half_pending   = (phase_q == PhHigh);
    assign total_cnt      = total_cnt_q;

endmodule

// File: tb/tb_fifo_pool_unpacker.sv
// Directed bench for fifo_pool_unpacker: FIFO model, word scoreboard and
// framing/flush/reset scenarios with BURST_WORDS=4.
module tb_fifo_pool_unpacker;

    localparam int unsigned Burst = 4;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        half_pending;
    logic [15:0] total_cnt;

    fifo_pool_unpacker_if bus ();

    fifo_pool_unpacker #(
        .BURST_WORDS(Burst),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .flush       (flush),
        .bus         (bus),
        .half_pending(half_pending),
        .total_cnt   (total_cnt)
    );

    always #5 clk = ~clk;

    // Standard (non-FWFT) FIFO model: data one cycle after the read strobe.
    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign bus.fifo_rd_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    exp_t sb [$];
    int   exp_idx = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [15:0] h);
        mem[wr_ptr] = h;
        wr_ptr++;
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_t e;
        e.data = w;
        e.last = ((exp_idx % Burst) == Burst - 1);
        sb.push_back(e);
        exp_idx++;
    endtask

    task automatic push_word(input logic [15:0] lo, input logic [15:0] hi);
        fifo_push(lo);
        fifo_push(hi);
        expect_word({hi, lo});
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        sb.delete();
        exp_idx = 0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int k = 0;
        while (sb.size() != 0 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare on each accepted word, plus hold stability.
    exp_t        mon_e;
    logic        held_valid = 1'b0;
    logic [32:0] held_word;
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_valid && bus.out_valid)
                check("stable", 64'({bus.out_last, bus.out_data}), 64'(held_word));
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_errors++;
                    $error("FAIL extra_word: observed %0h expected none", bus.out_data);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("word", 64'({bus.out_last, bus.out_data}), 64'({mon_e.last, mon_e.data}));
                end
            end
            held_valid = bus.out_valid & ~bus.out_ready;
            held_word  = {bus.out_last, bus.out_data};
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rd, t_ov, nrd, rd_start, n_re, odd;
        rst_n         = 1'b0;
        enable        = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        step(3);
        @(negedge clk);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_half", 64'(half_pending), 64'd0);
        check("rst_total", 64'(total_cnt), 64'd0);
        #2 rst_n = 1'b1;
        step(2);

        // Basic pairing and latency
        push_word(16'h1111, 16'h2222);
        push_word(16'h3333, 16'h4444);
        enable = 1'b1;
        t_rd = -1; t_ov = -1; nrd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) begin
                nrd++;
                if (nrd == 2) t_rd = k;
            end
            if (bus.out_valid && t_ov < 0) t_ov = k;
        end
        check("latency", 64'(t_ov - t_rd), 64'd3);
        drain("drain_basic", 50);
        check("basic_total", 64'(total_cnt), 64'd2);

        // Burst framing: 10 words, last on 4 and 8
        step(1);
        do_flush();
        for (int i = 0; i < 10; i++) push_word(16'(16'h0100 + i), 16'(16'h0200 + i));
        drain("drain_burst", 100);
        step(4);
        check("burst_total", 64'(total_cnt), 64'd10);
        check("burst_cnt", 64'(dut.burst_cnt_q), 64'd2);

        // Backpressure with a full FIFO
        bus.out_ready = 1'b0;
        do_flush();
        rd_start = rd_ptr;
        for (int i = 0; i < 10; i++) push_word(16'(16'h3000 + 2 * i), 16'(16'h3001 + 2 * i));
        step(50);
        @(negedge clk);
        check("stall_reads", 64'(rd_ptr - rd_start), 64'd5);
        check("stall_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("stall_occ", 64'(dut.occ_q), 64'd2);
        check("stall_half", 64'(half_pending), 64'd1);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        step(1);
        bus.out_ready = 1'b1;
        drain("drain_stall", 100);
        step(4);
        check("stall_total", 64'(total_cnt), 64'd10);

        // Odd half-word count
        do_flush();
        fifo_push(16'h000A);
        fifo_push(16'h000B);
        fifo_push(16'h000C);
        expect_word(32'h000B000A);
        step(20);
        check("odd_half", 64'(half_pending), 64'd1);
        check("odd_total", 64'(total_cnt), 64'd1);
        check("odd_sb", 64'(sb.size()), 64'd0);
        fifo_push(16'h000D);
        expect_word(32'h000D000C);
        drain("drain_odd", 50);
        step(4);
        check("odd_half2", 64'(half_pending), 64'd0);
        check("odd_total2", 64'(total_cnt), 64'd2);

        // Flush with a read in flight and one word buffered
        bus.out_ready = 1'b0;
        do_flush();
        fifo_push(16'h0101);
        fifo_push(16'h0202);
        for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
        check("fl_setup_valid", 64'(bus.out_valid), 64'd1);
        step(1);
        fifo_push(16'h0303);
        step(1);
        enable = 1'b0;
        flush  = 1'b1;
        @(negedge clk);
        check("fl_inflight", 64'(dut.rd_inflight_q), 64'd1);
        check("fl_occ", 64'(dut.occ_q), 64'd1);
        check("fl_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        step(1);
        flush = 1'b0;
        sb.delete();
        exp_idx = 0;
        @(negedge clk);
        check("fl_valid", 64'(bus.out_valid), 64'd0);
        check("fl_half", 64'(half_pending), 64'd0);
        check("fl_total", 64'(total_cnt), 64'd0);
        step(1);
        push_word(16'h0404, 16'h0505);
        bus.out_ready = 1'b1;
        enable = 1'b1;
        drain("drain_flush", 50);
        step(4);
        check("fl_total2", 64'(total_cnt), 64'd1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) push_word(16'(16'h5000 + 2 * i), 16'(16'h5001 + 2 * i));
        fifo_push(16'h7777);
        step(5);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("ar_valid", 64'(bus.out_valid), 64'd0);
        check("ar_data", 64'(bus.out_data), 64'd0);
        check("ar_last", 64'(bus.out_last), 64'd0);
        check("ar_half", 64'(half_pending), 64'd0);
        check("ar_total", 64'(total_cnt), 64'd0);
        sb.delete();
        exp_idx = 0;
        n_re = 0;
        for (int i = rd_ptr; i + 1 < wr_ptr; i += 2) begin
            expect_word({mem[i + 1], mem[i]});
            n_re++;
        end
        odd = (wr_ptr - rd_ptr) % 2;
        step(2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drain("drain_reset", 200);
        step(6);
        check("ar_total2", 64'(total_cnt), 64'(n_re));
        check("ar_half2", 64'(half_pending), 64'(odd));

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
